// File: rtl/rgb_led_sequencer.sv
// RGB status LED sequencer: static, blink, colour-cycle and triggered burst modes.
// Optional brightness PWM gating is built in when LED_PWM_EN is defined.
module rgb_led_sequencer #(
  parameter int TICK_DIV = 1,
  parameter int DWELL    = 2,
  parameter int BURST_N  = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] mode,
  input  logic [1:0] color_sel,
  input  logic       start,
`ifdef LED_PWM_EN
  input  logic [3:0] brightness,
`endif
  output logic       busy,
  output logic       done,
  output logic       led4_b,
  output logic       led4_g,
  output logic       led4_r
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = (DWELL    > 1) ? $clog2(DWELL)    : 1;
  localparam int BW = (BURST_N  > 1) ? $clog2(BURST_N)  : 1;
  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
  localparam logic [BW-1:0] BURST_LAST = BW'(BURST_N - 1);

  typedef enum logic [1:0] {IDLE, ON, OFF} state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   tick_q, tick_d;
  logic [DW-1:0]   dwell_q, dwell_d;
  logic [1:0]      idx_q, idx_d;
  logic [BW-1:0]   burst_q, burst_d;
  logic [1:0]      mode_q;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [2:0]      led_q, led_d;
  logic            tick, phase_end, restart;

  // {b,g,r}; shared by colour select and cycle index
  function automatic logic [2:0] color_of(input logic [1:0] c);
    case (c)
      2'b00:   color_of = 3'b111;
      2'b01:   color_of = 3'b001;
      2'b10:   color_of = 3'b010;
      default: color_of = 3'b011;
    endcase
  endfunction

  assign tick      = (tick_q == TICK_LAST);
  assign phase_end = tick && (dwell_q == DWELL_LAST);
  assign restart   = (mode != mode_q);

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    dwell_d = dwell_q;
    idx_d   = idx_q;
    burst_d = burst_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    if (!en || restart) begin
      state_d = (!en || mode == 2'b11) ? IDLE : ON;
      tick_d  = '0;
      dwell_d = '0;
      idx_d   = '0;
      burst_d = '0;
      busy_d  = 1'b0;
    end else begin
      if (state_q != IDLE) begin
        tick_d = tick ? '0 : tick_q + 1'b1;
        if (tick) dwell_d = phase_end ? '0 : dwell_q + 1'b1;
      end
      case (state_q)
        IDLE: begin
          // timing held at zero so every entry into ON gets a full phase
          tick_d  = '0;
          dwell_d = '0;
          if (mode != 2'b11) begin
            state_d = ON;
          end else if (start) begin
            state_d = ON;
            burst_d = '0;
            busy_d  = 1'b1;
          end
        end
        ON: begin
          if (phase_end) begin
            if (mode == 2'b10) idx_d = idx_q + 2'd1;
            else if (mode[0]) state_d = OFF;
          end
        end
        OFF: begin
          if (phase_end) begin
            if (mode == 2'b11 && burst_q == BURST_LAST) begin
              state_d = IDLE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              if (mode == 2'b11) burst_d = burst_q + 1'b1;
              state_d = ON;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
    led_d = 3'b000;
    if (state_d == ON) led_d = (mode == 2'b10) ? color_of(idx_d) : color_of(color_sel);
  end

`ifdef LED_PWM_EN
  logic [3:0] pwm_q;
  logic       gate;
  assign gate = (brightness == 4'hF) || (pwm_q < brightness);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tick_q  <= '0;
      dwell_q <= '0;
      idx_q   <= '0;
      burst_q <= '0;
      mode_q  <= 2'b00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      led_q   <= 3'b000;
`ifdef LED_PWM_EN
      pwm_q   <= 4'd0;
`endif
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      dwell_q <= dwell_d;
      idx_q   <= idx_d;
      burst_q <= burst_d;
      mode_q  <= mode;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef LED_PWM_EN
      pwm_q   <= pwm_q + 4'd1;
      led_q   <= led_d & {3{gate}};
`else
      led_q   <= led_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign {led4_b, led4_g, led4_r} = led_q;

endmodule

// File: tb/tb_rgb_led_sequencer.sv
// Bench for rgb_led_sequencer: directed vector table plus randomized run against a
// cycle-counting reference model, on two parameter sets.
module tb_rgb_led_sequencer;
  logic       clk = 1'b0;
  logic       rst, en, start;
  logic [1:0] mode, color_sel;
`ifdef LED_PWM_EN
  logic [3:0] brightness;
`endif
  logic busy_a, done_a, b_a, g_a, r_a;
  logic busy_b, done_b, b_b, g_b, r_b;

  always #5 clk = ~clk;

  rgb_led_sequencer #(.TICK_DIV(1), .DWELL(2), .BURST_N(2)) dut_a (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .color_sel(color_sel), .start(start),
`ifdef LED_PWM_EN
    .brightness(brightness),
`endif
    .busy(busy_a), .done(done_a), .led4_b(b_a), .led4_g(g_a), .led4_r(r_a));

  rgb_led_sequencer #(.TICK_DIV(3), .DWELL(2), .BURST_N(3)) dut_b (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .color_sel(color_sel), .start(start),
`ifdef LED_PWM_EN
    .brightness(brightness),
`endif
    .busy(busy_b), .done(done_b), .led4_b(b_b), .led4_g(g_b), .led4_r(r_b));

  int nchk = 0;
  int npass = 0;
  bit mchk = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: phases measured in whole clock cycles (L = TICK_DIV*DWELL).
  typedef struct {
    int         ph;     // 0 dark-idle, 1 lit, 2 dark-off
    int         el;     // cycles already spent in current phase
    int         idx;
    int         pairs;
    bit         busy;
    bit         done;
    logic [2:0] led;
    logic [1:0] prev;
  } mdl_t;

  logic [2:0] ctab [4] = '{3'b111, 3'b001, 3'b010, 3'b011};

  function automatic mdl_t mstep(input mdl_t s_in, input int L, input int bn);
    mdl_t s = s_in;
    bit   pend;
    s.done = 1'b0;
    if (rst) begin
      s.ph = 0; s.el = 0; s.idx = 0; s.pairs = 0; s.busy = 0; s.led = 3'b000; s.prev = 2'b00;
      return s;
    end
    if (!en || mode != s.prev) begin
      s.ph = (!en || mode == 2'b11) ? 0 : 1;
      s.el = 0; s.idx = 0; s.pairs = 0; s.busy = 0;
    end else if (s.ph == 0) begin
      if (mode != 2'b11) s.ph = 1;
      else if (start) begin s.ph = 1; s.pairs = 0; s.busy = 1; end
    end else begin
      pend = (s.el == L - 1);
      s.el = pend ? 0 : s.el + 1;
      if (pend) begin
        if (s.ph == 1) begin
          if (mode == 2'b10) s.idx = (s.idx + 1) % 4;
          else if (mode == 2'b01 || mode == 2'b11) s.ph = 2;
        end else if (mode == 2'b11) begin
          if (s.pairs == bn - 1) begin s.ph = 0; s.busy = 0; s.done = 1; end
          else begin s.pairs++; s.ph = 1; end
        end else s.ph = 1;
      end
    end
    s.led = (s.ph != 1) ? 3'b000 : (mode == 2'b10) ? ctab[s.idx] : ctab[color_sel];
    s.prev = mode;
    return s;
  endfunction

  mdl_t ma, mb;

  task automatic cyc();
    @(posedge clk);
    ma = mstep(ma, 1 * 2, 2);
    mb = mstep(mb, 3 * 2, 3);
    @(negedge clk);
    if (mchk) begin
      chk("A.led",  {b_a, g_a, r_a}, ma.led);
      chk("A.busy", busy_a, ma.busy);
      chk("A.done", done_a, ma.done);
      chk("B.led",  {b_b, g_b, r_b}, mb.led);
      chk("B.busy", busy_b, mb.busy);
      chk("B.done", done_b, mb.done);
    end
  endtask

  typedef struct {
    bit rst; bit en; bit [1:0] mode; bit [1:0] col; bit start;
    bit [2:0] led; bit busy; bit done;
  } vec_t;

  function automatic vec_t mk(bit r, bit e, bit [1:0] m, bit [1:0] c, bit s,
                              bit [2:0] l, bit bz, bit d);
    vec_t v;
    v.rst = r; v.en = e; v.mode = m; v.col = c; v.start = s; v.led = l; v.busy = bz; v.done = d;
    return v;
  endfunction

  vec_t tv [46];
  int   cnt_b, cnt_g, cnt_r;

  initial begin
    // reset, then cycle mode; en drop at idx 2
    tv[0]  = mk(1,1,2,0,0,3'b000,0,0); tv[1]  = mk(1,1,2,0,0,3'b000,0,0);
    tv[2]  = mk(0,1,2,0,0,3'b111,0,0); tv[3]  = mk(0,1,2,0,0,3'b111,0,0);
    tv[4]  = mk(0,1,2,0,0,3'b001,0,0); tv[5]  = mk(0,1,2,0,0,3'b001,0,0);
    tv[6]  = mk(0,1,2,0,0,3'b010,0,0); tv[7]  = mk(0,1,2,0,0,3'b010,0,0);
    tv[8]  = mk(0,1,2,0,0,3'b011,0,0); tv[9]  = mk(0,1,2,0,0,3'b011,0,0);
    tv[10] = mk(0,1,2,0,0,3'b111,0,0); tv[11] = mk(0,1,2,0,0,3'b111,0,0);
    tv[12] = mk(0,1,2,0,0,3'b001,0,0); tv[13] = mk(0,1,2,0,0,3'b001,0,0);
    tv[14] = mk(0,1,2,0,0,3'b010,0,0);
    tv[15] = mk(0,0,2,0,0,3'b000,0,0); tv[16] = mk(0,0,2,0,0,3'b000,0,0);
    tv[17] = mk(0,0,2,0,0,3'b000,0,0);
    tv[18] = mk(0,1,2,0,0,3'b111,0,0); tv[19] = mk(0,1,2,0,0,3'b111,0,0);
    tv[20] = mk(0,1,2,0,0,3'b001,0,0);
    // blink red
    tv[21] = mk(0,1,1,1,0,3'b001,0,0); tv[22] = mk(0,1,1,1,0,3'b001,0,0);
    tv[23] = mk(0,1,1,1,0,3'b000,0,0); tv[24] = mk(0,1,1,1,0,3'b000,0,0);
    tv[25] = mk(0,1,1,1,0,3'b001,0,0); tv[26] = mk(0,1,1,1,0,3'b001,0,0);
    tv[27] = mk(0,1,1,1,0,3'b000,0,0);
    // burst: start, re-start while busy, completion with a coincident start
    tv[28] = mk(0,1,3,1,0,3'b000,0,0); tv[29] = mk(0,1,3,1,0,3'b000,0,0);
    tv[30] = mk(0,1,3,1,1,3'b001,1,0); tv[31] = mk(0,1,3,1,1,3'b001,1,0);
    tv[32] = mk(0,1,3,1,0,3'b000,1,0); tv[33] = mk(0,1,3,1,0,3'b000,1,0);
    tv[34] = mk(0,1,3,1,0,3'b001,1,0); tv[35] = mk(0,1,3,1,0,3'b001,1,0);
    tv[36] = mk(0,1,3,1,0,3'b000,1,0); tv[37] = mk(0,1,3,1,0,3'b000,1,0);
    tv[38] = mk(0,1,3,1,1,3'b000,0,1); tv[39] = mk(0,1,3,1,0,3'b000,0,0);
    // burst aborted by mode change, then colour change without restart
    tv[40] = mk(0,1,3,1,1,3'b001,1,0); tv[41] = mk(0,1,3,1,0,3'b001,1,0);
    tv[42] = mk(0,1,3,1,0,3'b000,1,0);
    tv[43] = mk(0,1,0,2,0,3'b010,0,0); tv[44] = mk(0,1,0,2,0,3'b010,0,0);
    tv[45] = mk(0,1,0,3,0,3'b011,0,0);

    rst = 1'b1; en = 1'b1; mode = 2'b10; color_sel = 2'b00; start = 1'b0;
`ifdef LED_PWM_EN
    brightness = 4'hF;
`endif
    ma = '{default: 0}; mb = '{default: 0};
    @(negedge clk);

    for (int i = 0; i < 46; i++) begin
      rst = tv[i].rst; en = tv[i].en; mode = tv[i].mode;
      color_sel = tv[i].col; start = tv[i].start;
      cyc();
      chk($sformatf("vec%0d.led", i),  {b_a, g_a, r_a}, tv[i].led);
      chk($sformatf("vec%0d.busy", i), busy_a, tv[i].busy);
      chk($sformatf("vec%0d.done", i), done_a, tv[i].done);
    end

    // burst start with B's longer timing, then a mid-burst reset
    mode = 2'b11; start = 1'b0; cyc();
    start = 1'b1; cyc();
    start = 1'b0;
    for (int i = 0; i < 8; i++) cyc();
    rst = 1'b1; cyc();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) cyc();

    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(0, 149) == 0);
      en    = ($urandom_range(0, 24) != 0);
      if ($urandom_range(0, 59) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 11) == 0) color_sel = 2'($urandom_range(0, 3));
      start = ($urandom_range(0, 7) == 0);
      cyc();
    end

`ifdef LED_PWM_EN
    mchk = 1'b0;
    rst = 1'b0; en = 1'b1; mode = 2'b00; color_sel = 2'b00; start = 1'b0;
    for (int b = 0; b < 3; b++) begin
      brightness = (b == 0) ? 4'd4 : (b == 1) ? 4'd15 : 4'd0;
      cyc(); cyc(); cyc();
      cnt_b = 0; cnt_g = 0; cnt_r = 0;
      for (int i = 0; i < 16; i++) begin
        cyc();
        cnt_b += int'(b_a); cnt_g += int'(g_a); cnt_r += int'(r_a);
      end
      chk($sformatf("pwm%0d.b", brightness), cnt_b, (b == 0) ? 4 : (b == 1) ? 16 : 0);
      chk($sformatf("pwm%0d.g", brightness), cnt_g, (b == 0) ? 4 : (b == 1) ? 16 : 0);
      chk($sformatf("pwm%0d.r", brightness), cnt_r, (b == 0) ? 4 : (b == 1) ? 16 : 0);
    end
`endif

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
